// File: rtl/mux_sel_pkg.sv
// Shared select type, reset value and LED decode for the mux select controller.
package mux_sel_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RESET = 2'b00;

  function automatic logic [3:0] sel_to_onehot(input sel_t sel);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer; `level` is the accepted button level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // The level flips only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_ctrl.sv
// Button/auto-scan driven 2-bit select for a 4:1 mux slice.
// Auto-scan timer is present only when MUX_SEL_AUTOSCAN_EN is defined.
module mux_sel_ctrl
  import mux_sel_pkg::*;
#(
  parameter int DB_CYCLES   = 1000000,
  parameter int SCAN_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       btn_dir,
  input  logic       auto_en,
  output logic [1:0] s,
  output logic [3:0] sel_onehot,
  output logic       step
);

  logic       level;
  logic       level_d;
  logic       press_q;
  logic [1:0] dir_sync;
  logic       advance;
  sel_t       s_next;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_step),
    .level  (level)
  );

  // Registered rising-edge detect: releases never produce a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_sync <= 2'b00;
      level_d  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      dir_sync <= {dir_sync[0], btn_dir};
      level_d  <= level;
      press_q  <= level & ~level_d;
    end
  end

`ifdef MUX_SEL_AUTOSCAN_EN
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic [1:0]    auto_sync;
  logic [SW-1:0] scan_cnt;
  logic          scan_tc;

  assign scan_tc = auto_sync[1] && (scan_cnt == SCAN_LAST);

  // A press restarts the scan period so the next auto step is a full period away.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_sync <= 2'b00;
      scan_cnt  <= '0;
    end else begin
      auto_sync <= {auto_sync[0], auto_en};
      if (!auto_sync[1] || press_q || scan_tc) begin
        scan_cnt <= '0;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign advance = press_q | scan_tc;
`else
  localparam int unused_scan_cycles = SCAN_CYCLES;
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign advance        = press_q;
`endif

  always_comb begin
    s_next = s;
    if (advance) begin
      s_next = dir_sync[1] ? s - 2'd1 : s + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= SEL_RESET;
      sel_onehot <= sel_to_onehot(SEL_RESET);
      step       <= 1'b0;
    end else begin
      s          <= s_next;
      sel_onehot <= sel_to_onehot(s_next);
      step       <= advance;
    end
  end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl: vector table, corner sequences, random run vs model.
// Auto-scan sequences are exercised when MUX_SEL_AUTOSCAN_EN is defined.
`timescale 1ns/1ps
module tb_mux_sel_ctrl;

  localparam int DB   = 4;
  localparam int SCAN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_step;
  logic       btn_dir;
  logic       auto_en;
  logic [1:0] s;
  logic [3:0] sel_onehot;
  logic       step;

  int checks = 0;
  int passes = 0;
  int step_seen = 0;

  always #5 clk = ~clk;

  mux_sel_ctrl #(
    .DB_CYCLES  (DB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_step  (btn_step),
    .btn_dir   (btn_dir),
    .auto_en   (auto_en),
    .s         (s),
    .sel_onehot(sel_onehot),
    .step      (step)
  );

  // Reference model: raw input history, stable-run length, fixed pipeline latencies.
  logic btn_hist[$];
  logic dir_hist[$];
  logic auto_hist[$];
  logic m_acc;
  int   m_run;
  int   m_phase;
  int   m_cycle = 0;
  int   m_press_at;
  int   m_s;
  logic m_step;

  function automatic void model_reset();
    btn_hist   = '{1'b0, 1'b0};
    dir_hist   = '{1'b0, 1'b0};
    auto_hist  = '{1'b0, 1'b0};
    m_acc      = 1'b0;
    m_run      = 0;
    m_phase    = 0;
    m_press_at = -1;
    m_s        = 0;
    m_step     = 1'b0;
  endfunction

  function automatic void model_edge();
    logic adv;
    if (rst) begin
      model_reset();
      return;
    end
    btn_hist.push_front(btn_step);
    dir_hist.push_front(btn_dir);
    if (btn_hist.size() > 3) void'(btn_hist.pop_back());
    if (dir_hist.size() > 3) void'(dir_hist.pop_back());
    m_cycle++;
    adv = (m_cycle == m_press_at);
`ifdef MUX_SEL_AUTOSCAN_EN
    auto_hist.push_front(auto_en);
    if (auto_hist.size() > 3) void'(auto_hist.pop_back());
    if (auto_hist[2] && m_phase == SCAN - 1) begin
      m_phase = 0;
      adv     = 1'b1;
    end else if (!auto_hist[2] || m_cycle == m_press_at) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
    if (m_cycle == m_press_at) m_phase = 0;
`endif
    if (btn_hist[2] != m_acc) begin
      m_run++;
      if (m_run == DB) begin
        m_acc = ~m_acc;
        m_run = 0;
        if (m_acc) m_press_at = m_cycle + 2;
      end
    end else begin
      m_run = 0;
    end
    m_step = adv;
    if (adv) m_s = dir_hist[2] ? (m_s + 3) % 4 : (m_s + 1) % 4;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (step === 1'b1) step_seen++;
    checkOutput("model_s", {6'd0, s}, 8'(m_s));
    checkOutput("model_onehot", {4'd0, sel_onehot}, 8'(1 << m_s));
    checkOutput("model_step", {7'd0, step}, {7'd0, m_step});
  endtask

  task automatic applyStimulus(input logic b, input logic d, input logic a, input int n);
    btn_step = b;
    btn_dir  = d;
    auto_en  = a;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    rst = 1'b0;
  endtask

  typedef struct {
    int         high;
    int         low;
    logic       dir;
    logic [1:0] exp_s;
    logic [3:0] exp_oh;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{12, 12, 1'b0, 2'd1, 4'b0010};
    vecs[1] = '{12, 12, 1'b0, 2'd2, 4'b0100};
    vecs[2] = '{12, 12, 1'b0, 2'd3, 4'b1000};
    vecs[3] = '{12, 12, 1'b0, 2'd0, 4'b0001};
    vecs[4] = '{12, 12, 1'b1, 2'd3, 4'b1000};
    vecs[5] = '{3,  10, 1'b0, 2'd3, 4'b1000};
    vecs[6] = '{4,  10, 1'b0, 2'd0, 4'b0001};
    vecs[7] = '{12, 12, 1'b1, 2'd3, 4'b1000};
    vecs[8] = '{12, 12, 1'b1, 2'd2, 4'b0100};

    model_reset();
    rst = 1'b1; btn_step = 1'b0; btn_dir = 1'b0; auto_en = 1'b0;
    do_reset();
    checkOutput("reset_s", {6'd0, s}, 8'd0);
    checkOutput("reset_onehot", {4'd0, sel_onehot}, 8'b0001);
    checkOutput("reset_step", {7'd0, step}, 8'd0);

    // Press latency: s moves on the 8th edge after the button goes high.
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkOutput("lat_before", {6'd0, s}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lat_s", {6'd0, s}, 8'd1);
    checkOutput("lat_step", {7'd0, step}, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lat_step_clear", {7'd0, step}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].dir, 1'b0, vecs[i].high);
      applyStimulus(1'b0, vecs[i].dir, 1'b0, vecs[i].low);
      checkOutput($sformatf("vec%0d_s", i), {6'd0, s}, {6'd0, vecs[i].exp_s});
      checkOutput($sformatf("vec%0d_onehot", i), {4'd0, sel_onehot}, {4'd0, vecs[i].exp_oh});
    end

    // Bouncing button: only the final stable press counts.
    step_seen = 0;
    for (int i = 0; i < 10; i++) applyStimulus(i % 2 == 0, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);
    checkOutput("bounce_steps", 8'(step_seen), 8'd1);
    checkOutput("bounce_s", {6'd0, s}, 8'd3);

    // Reset in the middle of a debounce with the button held.
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    rst = 1'b0;
    checkOutput("midrst_s", {6'd0, s}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkOutput("midrst_hold", {6'd0, s}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("midrst_adv", {6'd0, s}, 8'd1);
    checkOutput("midrst_step", {7'd0, step}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);

    do_reset();
    step_seen = 0;
`ifdef MUX_SEL_AUTOSCAN_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 10);
    checkOutput("auto_first", {6'd0, s}, 8'd1);
    checkOutput("auto_first_step", {7'd0, step}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8);
    checkOutput("auto_second", {6'd0, s}, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 7);
    checkOutput("auto_pre_coinc", {6'd0, s}, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("auto_coinc", {6'd0, s}, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 7);
    checkOutput("auto_after_coinc", {6'd0, s}, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("auto_next", {6'd0, s}, 8'd0);
    checkOutput("auto_step_count", 8'(step_seen), 8'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);
`else
    applyStimulus(1'b0, 1'b0, 1'b1, 24);
    checkOutput("auto_ignored_s", {6'd0, s}, 8'd0);
    checkOutput("auto_ignored_steps", 8'(step_seen), 8'd0);
`endif

    // Random run against the model, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      logic b, d, a;
      int   n;
      b = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 12);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        applyStimulus(b, d, a, 1);
        rst = 1'b0;
      end else begin
        applyStimulus(b, d, a, n);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000: number of consecutive stable cycles required to accept a button level change (minimum 2).
REQ-002 SHALL have parameter SCAN_CYCLES, default 50000000: auto-scan advance period in clk cycles (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port btn_step, input, 1 bit: raw, asynchronous, bouncing push-button, active-high.
REQ-006 SHALL have port btn_dir, input, 1 bit: raw slide switch selecting direction; 0 = up, 1 = down.
REQ-007 SHALL have port auto_en, input, 1 bit: raw slide switch; 1 enables auto-scan.
REQ-008 SHALL have port s, output, 2 bits: registered select that drives the downstream 4:1 mux slice select input.
REQ-009 SHALL have port sel_onehot, output, 4 bits: registered one-hot decode of s for board LEDs; bit n is high when s equals n.
REQ-010 SHALL have port step, output, 1 bit: one-cycle pulse, high in exactly the cycle in which s first shows a new value.

Function
REQ-011 SHALL pass btn_step, btn_dir and auto_en each through a 2-flop synchronizer before any use.
REQ-012 SHALL debounce the synchronized btn_step with a counter that behaves as follows:
- Clears whenever the input equals the accepted level.
- Otherwise increments each cycle.
- On reaching DB_CYCLES-1, toggles the accepted level and clears.
REQ-013 SHALL form a one-cycle press event on the rising edge of the accepted level only; releases produce no event and generate no step pulse.
REQ-014 SHALL, on an advance event, update s as follows:
- Direction 0: s <= s+1 modulo 4 (3 wraps to 0).
- Direction 1: s <= s-1 modulo 4 (0 wraps to 3).
- Direction is the synchronized btn_dir value sampled in that same cycle.
REQ-015 SHALL update s, sel_onehot and step in the cycle after the advance event (one register stage).
REQ-016 SHALL, with auto-scan compiled in and synchronized auto_en high, run the scan timer as follows:
- Counts 0..SCAN_CYCLES-1.
- Generates an advance event at the terminal count.
- Wraps to 0.
REQ-017 SHALL hold the scan timer at 0 while synchronized auto_en is low.
REQ-018 SHALL, when a press event and a scan terminal count occur in the same cycle, perform exactly one advance.
REQ-019 SHALL restart the scan timer at 0 on any press event.
REQ-020 SHALL ignore btn_dir changes between advance events; s SHALL change only on advance events.
REQ-021 SHALL, from the first rising edge at which btn_step is high and then stays high, change s after exactly DB_CYCLES+4 cycles (2 synchronizer stages, debounce, edge detect, output register).

Reset
REQ-022 SHALL, while rst is high at a rising clk edge, set the following:
- Outputs: s=2'b00, sel_onehot=4'b0001, step=0.
- Internal state: synchronizers=0, accepted level=0, debounce counter=0, scan timer=0.
REQ-023 SHALL discard any in-progress debounce or scan count when rst is asserted mid-operation; a button held through reset release SHALL be accepted as a new press after DB_CYCLES+4 cycles.

Configuration
REQ-024 SHALL compile the scan timer and REQ-016 to REQ-019 (timer part) only when macro MUX_SEL_AUTOSCAN_EN is defined.
REQ-025 SHALL, with MUX_SEL_AUTOSCAN_EN undefined, keep the auto_en port but ignore it and contain no scan timer logic; only presses advance s.

Structure
REQ-026 SHALL take from shared package mux_sel_pkg the following:
- typedef sel_t (2-bit select).
- Constant SEL_RESET = 2'b00.
- Decode function sel_to_onehot.
REQ-027 SHALL instantiate one sub-module btn_debounce (synchronizer + debounce counter + accepted level, parameter DB_CYCLES) for btn_step.

Verification (DB_CYCLES=4, SCAN_CYCLES=8)
REQ-028 SHALL cover: rst high 3 cycles -> s=0, sel_onehot=0001, step=0.
REQ-029 SHALL cover: btn_step high clean, btn_dir=0 -> s=1 exactly 8 cycles later with a single step pulse; four presses -> s sequence 1,2,3,0.
REQ-030 SHALL cover: btn_step toggling every 2 cycles for 20 cycles, then high -> exactly one advance.
REQ-031 SHALL cover: btn_dir=1, one press from s=0 -> s=3, sel_onehot=1000.
REQ-032 SHALL cover (macro defined): auto_en high, no presses -> s advances every 8 cycles; press coincident with terminal count -> a single advance and the next auto advance 8 cycles later.
REQ-033 SHALL cover: rst asserted mid-debounce with btn_step held -> s stays 0 and advances 8 cycles after rst deasserts.
